// File: rtl/xbar_rr_nxm.sv
// ---------------------------------------------------------------------------
// xbar_rr_nxm
//
// Parametrised N-master x M-slave request/ack crossbar. The top SEL_W address
// bits pick the slave. Each slave has its own round-robin arbiter FSM
// (IDLE -> REQ -> RESP) that forwards the granted master's command, waits for
// s_ack (or a timeout), and returns one registered ack/rdata/err pulse to
// that master. An address that decodes past the last slave is answered by a
// per-master error responder one cycle later without touching any slave.
//
// Handshake: a master raises m_req with cmd/addr/wdata and keeps them stable
// until it sees m_ack for one cycle. m_req high in the cycle after m_ack is a
// new transaction. A slave sees s_req held with stable cmd/addr/wdata until it
// pulses s_ack. s_ack is only looked at while that slave's FSM is in REQ.
//
// Ports
//   clk, rst               clock; synchronous active-high reset
//   m_req/m_cmd            per-master request and command (1 = write)
//   m_addr/m_wdata         per-master address/write data, packed [i*W +: W]
//   m_rdata/m_ack/m_err    per-master response (rdata valid with m_ack)
//   s_req/s_cmd            per-slave request and forwarded command
//   s_addr/s_wdata         per-slave forwarded address/write data
//   s_rdata/s_ack          per-slave read data and completion
//   dbg_state              per-slave FSM state, packed [2*j +: 2]
// ---------------------------------------------------------------------------
module xbar_rr_nxm #(
    parameter int N_MASTERS = 2,
    parameter int N_SLAVES  = 2,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int TIMEOUT   = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_MASTERS-1:0]     m_req,
    input  logic [N_MASTERS-1:0]     m_cmd,
    input  logic [N_MASTERS*AW-1:0]  m_addr,
    input  logic [N_MASTERS*DW-1:0]  m_wdata,
    output logic [N_MASTERS*DW-1:0]  m_rdata,
    output logic [N_MASTERS-1:0]     m_ack,
    output logic [N_MASTERS-1:0]     m_err,
    output logic [N_SLAVES-1:0]      s_req,
    output logic [N_SLAVES-1:0]      s_cmd,
    output logic [N_SLAVES*AW-1:0]   s_addr,
    output logic [N_SLAVES*DW-1:0]   s_wdata,
    input  logic [N_SLAVES*DW-1:0]   s_rdata,
    input  logic [N_SLAVES-1:0]      s_ack,
    output logic [2*N_SLAVES-1:0]    dbg_state
);

    localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int MW    = $clog2(N_MASTERS);
    localparam int CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Counter value in the last REQ cycle before the timeout response.
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          state_q  [N_SLAVES];
    state_t          state_nx [N_SLAVES];
    logic [MW-1:0]   rr_ptr_q [N_SLAVES];
    logic [MW-1:0]   gnt_q    [N_SLAVES];
    logic            cmd_q    [N_SLAVES];
    logic [AW-1:0]   addr_q   [N_SLAVES];
    logic [DW-1:0]   wdata_q  [N_SLAVES];
    logic [DW-1:0]   rdata_q  [N_SLAVES];
    logic            err_q    [N_SLAVES];
    logic [CW-1:0]   cnt_q    [N_SLAVES];

    logic            arb_hit  [N_SLAVES];
    logic [MW-1:0]   arb_idx  [N_SLAVES];
    logic            expire   [N_SLAVES];

    logic [SEL_W-1:0]      m_sel [N_MASTERS];
    logic [N_MASTERS-1:0]  m_dec_err;
    logic [N_MASTERS-1:0]  err_pend_q;

    // Address decode per master.
    always_comb begin
        for (int i = 0; i < N_MASTERS; i++) begin
            m_sel[i]     = m_addr[i*AW + AW - SEL_W +: SEL_W];
            m_dec_err[i] = (int'(m_sel[i]) >= N_SLAVES);
        end
    end

    // Round-robin pick per slave: scan upward from rr_ptr, first hit wins.
    always_comb begin
        for (int j = 0; j < N_SLAVES; j++) begin
            arb_hit[j] = 1'b0;
            arb_idx[j] = '0;
            for (int off = 0; off < N_MASTERS; off++) begin
                int idx;
                idx = (int'(rr_ptr_q[j]) + off) % N_MASTERS;
                if (!arb_hit[j] && m_req[idx] && (int'(m_sel[idx]) == j)) begin
                    arb_hit[j] = 1'b1;
                    arb_idx[j] = MW'(idx);
                end
            end
            expire[j] = (TIMEOUT != 0) && (cnt_q[j] == TO_LAST);
        end
    end

    // FSM: state register.
    always_ff @(posedge clk) begin
        for (int j = 0; j < N_SLAVES; j++) begin
            if (rst) state_q[j] <= S_IDLE;
            else     state_q[j] <= state_nx[j];
        end
    end

    // FSM: next state. An ack in the expiry cycle still ends in RESP, with
    // the datapath below deciding that the ack wins.
    always_comb begin
        for (int j = 0; j < N_SLAVES; j++) begin
            state_nx[j] = state_q[j];
            case (state_q[j])
                S_IDLE:  if (arb_hit[j]) state_nx[j] = S_REQ;
                S_REQ:   if (s_ack[j] || expire[j]) state_nx[j] = S_RESP;
                S_RESP:  state_nx[j] = S_IDLE;
                default: state_nx[j] = S_IDLE;
            endcase
        end
    end

    // Per-slave datapath: grant capture, timeout counter, response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < N_SLAVES; j++) begin
                rr_ptr_q[j] <= '0;
                gnt_q[j]    <= '0;
                cmd_q[j]    <= 1'b0;
                addr_q[j]   <= '0;
                wdata_q[j]  <= '0;
                rdata_q[j]  <= '0;
                err_q[j]    <= 1'b0;
                cnt_q[j]    <= '0;
            end
            err_pend_q <= '0;
        end else begin
            for (int j = 0; j < N_SLAVES; j++) begin
                case (state_q[j])
                    S_IDLE: begin
                        if (arb_hit[j]) begin
                            gnt_q[j]   <= arb_idx[j];
                            cmd_q[j]   <= m_cmd[arb_idx[j]];
                            addr_q[j]  <= m_addr[int'(arb_idx[j])*AW +: AW];
                            wdata_q[j] <= m_wdata[int'(arb_idx[j])*DW +: DW];
                            cnt_q[j]   <= '0;
                        end
                    end
                    S_REQ: begin
                        if (s_ack[j]) begin
                            rdata_q[j] <= cmd_q[j] ? '0 : s_rdata[j*DW +: DW];
                            err_q[j]   <= 1'b0;
                        end else if (expire[j]) begin
                            rdata_q[j] <= '0;
                            err_q[j]   <= 1'b1;
                        end else begin
                            cnt_q[j]   <= cnt_q[j] + 1'b1;
                        end
                    end
                    S_RESP: begin
                        rr_ptr_q[j] <= MW'((int'(gnt_q[j]) + 1) % N_MASTERS);
                        cnt_q[j]    <= '0;
                    end
                    default: ;
                endcase
            end
            // Error responder answers one cycle later, then skips the cycle
            // in which the master still holds the same request.
            err_pend_q <= m_req & m_dec_err & ~err_pend_q;
        end
    end

    // FSM: outputs. Only one source is active per master in any cycle, so
    // the per-master responses are a plain OR.
    always_comb begin
        s_req     = '0;
        s_cmd     = '0;
        s_addr    = '0;
        s_wdata   = '0;
        m_ack     = '0;
        m_err     = '0;
        m_rdata   = '0;
        dbg_state = '0;
        for (int j = 0; j < N_SLAVES; j++) begin
            dbg_state[2*j +: 2] = state_q[j];
            if (state_q[j] == S_REQ) begin
                s_req[j]              = 1'b1;
                s_cmd[j]              = cmd_q[j];
                s_addr[j*AW +: AW]    = addr_q[j];
                s_wdata[j*DW +: DW]   = wdata_q[j];
            end
            if (state_q[j] == S_RESP) begin
                m_ack[gnt_q[j]] = 1'b1;
                m_err[gnt_q[j]] = m_err[gnt_q[j]] | err_q[j];
                m_rdata[int'(gnt_q[j])*DW +: DW] =
                    m_rdata[int'(gnt_q[j])*DW +: DW] | rdata_q[j];
            end
        end
        for (int i = 0; i < N_MASTERS; i++) begin
            if (err_pend_q[i]) begin
                m_ack[i] = 1'b1;
                m_err[i] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_xbar_rr_nxm.sv
// ---------------------------------------------------------------------------
// tb_xbar_rr_nxm
//
// Directed bench for xbar_rr_nxm. "dut" is a 2x2 crossbar with TIMEOUT=4
// (slave index = addr[31]); "dut3" is a 2x3 crossbar (slave index =
// addr[31:30]) used for decode errors. Cycle c is the clock period that
// starts at the c-th rising edge of a test; inputs change 1 ns after that
// edge and outputs are sampled on the following falling edge.
// ---------------------------------------------------------------------------
module tb_xbar_rr_nxm;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  m_req, m_cmd, m_ack, m_err;
    logic [63:0] m_addr, m_wdata, m_rdata;
    logic [1:0]  s_req, s_cmd, s_ack;
    logic [63:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  dbg_state;

    logic [1:0]  d3_m_req, d3_m_cmd, d3_m_ack, d3_m_err;
    logic [63:0] d3_m_addr, d3_m_wdata, d3_m_rdata;
    logic [2:0]  d3_s_req, d3_s_cmd, d3_s_ack;
    logic [95:0] d3_s_addr, d3_s_wdata, d3_s_rdata;
    logic [5:0]  d3_dbg_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xbar_rr_nxm #(.N_MASTERS(2), .N_SLAVES(2), .AW(32), .DW(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .m_req(m_req), .m_cmd(m_cmd), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack), .m_err(m_err),
        .s_req(s_req), .s_cmd(s_cmd), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ack(s_ack), .dbg_state(dbg_state)
    );

    xbar_rr_nxm #(.N_MASTERS(2), .N_SLAVES(3), .AW(32), .DW(32), .TIMEOUT(4)) dut3 (
        .clk(clk), .rst(rst),
        .m_req(d3_m_req), .m_cmd(d3_m_cmd), .m_addr(d3_m_addr), .m_wdata(d3_m_wdata),
        .m_rdata(d3_m_rdata), .m_ack(d3_m_ack), .m_err(d3_m_err),
        .s_req(d3_s_req), .s_cmd(d3_s_cmd), .s_addr(d3_s_addr), .s_wdata(d3_s_wdata),
        .s_rdata(d3_s_rdata), .s_ack(d3_s_ack), .dbg_state(d3_dbg_state)
    );

    task automatic clear_inputs();
        m_req = '0; m_cmd = '0; m_addr = '0; m_wdata = '0; s_rdata = '0; s_ack = '0;
        d3_m_req = '0; d3_m_cmd = '0; d3_m_addr = '0; d3_m_wdata = '0;
        d3_s_rdata = '0; d3_s_ack = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        m_req = 2'b11;
        m_addr = {32'h8000_0000, 32'h0000_0000};
        s_ack = 2'b11;
        s_rdata = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (s_req !== 2'b00) begin errors++; $display("FAIL reset s_req: got %b want 00", s_req); end
        checks++; if (m_ack !== 2'b00) begin errors++; $display("FAIL reset m_ack: got %b want 00", m_ack); end
        checks++; if (m_err !== 2'b00) begin errors++; $display("FAIL reset m_err: got %b want 00", m_err); end
        checks++; if (m_rdata !== 64'h0) begin errors++; $display("FAIL reset m_rdata: got %h want 0", m_rdata); end
        checks++; if (s_addr !== 64'h0) begin errors++; $display("FAIL reset s_addr: got %h want 0", s_addr); end
        checks++; if (s_cmd !== 2'b00) begin errors++; $display("FAIL reset s_cmd: got %b want 00", s_cmd); end
        checks++; if (dbg_state !== 4'h0) begin errors++; $display("FAIL reset dbg_state: got %h want 0", dbg_state); end
        checks++; if (d3_m_ack !== 2'b00) begin errors++; $display("FAIL reset d3_m_ack: got %b want 00", d3_m_ack); end
        clear_inputs();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // m0 reads s1; s1 acks in cycle 3.
    task automatic test_read();
        logic [1:0] exp_req, exp_ack;
        do_reset();
        for (int c = 0; c <= 5; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin m_req = 2'b01; m_cmd = 2'b00; m_addr[31:0] = 32'h8000_0010; end
            s_ack = (c == 3) ? 2'b10 : 2'b00;
            s_rdata[63:32] = (c == 3) ? 32'hA5A5_0001 : 32'h0;
            if (c == 5) m_req = 2'b00;
            @(negedge clk);
            exp_req = (c >= 1 && c <= 3) ? 2'b10 : 2'b00;
            exp_ack = (c == 4) ? 2'b01 : 2'b00;
            checks++; if (s_req !== exp_req) begin errors++; $display("FAIL read s_req c%0d: got %b want %b", c, s_req, exp_req); end
            checks++; if (m_ack !== exp_ack) begin errors++; $display("FAIL read m_ack c%0d: got %b want %b", c, m_ack, exp_ack); end
            checks++; if (m_err !== 2'b00) begin errors++; $display("FAIL read m_err c%0d: got %b want 00", c, m_err); end
            if (c == 2) begin
                checks++; if (s_addr[63:32] !== 32'h8000_0010) begin errors++; $display("FAIL read s_addr c%0d: got %h want 80000010", c, s_addr[63:32]); end
            end
            if (c == 4) begin
                checks++; if (m_rdata[31:0] !== 32'hA5A5_0001) begin errors++; $display("FAIL read m_rdata c%0d: got %h want a5a50001", c, m_rdata[31:0]); end
            end
        end
    endtask

    // Both masters keep writing s0; s0 acks every REQ cycle at once.
    task automatic test_contention();
        logic [1:0]  exp_ack;
        logic        exp_req;
        logic [31:0] exp_addr, exp_wdata;
        int g;
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                m_req = 2'b11; m_cmd = 2'b11;
                m_addr  = {32'h0000_0200, 32'h0000_0100};
                m_wdata = {32'h2222_0000, 32'h1111_0000};
                s_ack = 2'b01;
            end
            if (c == 12) begin m_req = 2'b00; s_ack = 2'b00; end
            @(negedge clk);
            g = (c / 3) % 2;
            exp_req   = (c >= 1 && c <= 10 && (c % 3) == 1);
            exp_ack   = (c >= 2 && (c % 3) == 2) ? ((g == 0) ? 2'b01 : 2'b10) : 2'b00;
            exp_addr  = (g == 0) ? 32'h0000_0100 : 32'h0000_0200;
            exp_wdata = (g == 0) ? 32'h1111_0000 : 32'h2222_0000;
            checks++; if (s_req !== {1'b0, exp_req}) begin errors++; $display("FAIL contention s_req c%0d: got %b want %b", c, s_req, {1'b0, exp_req}); end
            checks++; if (m_ack !== exp_ack) begin errors++; $display("FAIL contention m_ack c%0d: got %b want %b", c, m_ack, exp_ack); end
            if (exp_req) begin
                checks++; if (s_addr[31:0] !== exp_addr) begin errors++; $display("FAIL contention s_addr c%0d: got %h want %h", c, s_addr[31:0], exp_addr); end
                checks++; if (s_wdata[31:0] !== exp_wdata) begin errors++; $display("FAIL contention s_wdata c%0d: got %h want %h", c, s_wdata[31:0], exp_wdata); end
                checks++; if (s_cmd !== 2'b01) begin errors++; $display("FAIL contention s_cmd c%0d: got %b want 01", c, s_cmd); end
            end
        end
    endtask

    // m0 reads s0 while m1 writes s1 in the same cycles.
    task automatic test_parallel();
        do_reset();
        for (int c = 0; c <= 3; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                m_req = 2'b11; m_cmd = 2'b10;
                m_addr  = {32'h8000_0080, 32'h0000_0040};
                m_wdata = {32'hDEAD_BEEF, 32'h0000_0000};
            end
            s_ack   = (c == 1) ? 2'b11 : 2'b00;
            s_rdata = (c == 1) ? {32'hFFFF_FFFF, 32'h1234_5678} : 64'h0;
            if (c == 3) m_req = 2'b00;
            @(negedge clk);
            if (c == 1) begin
                checks++; if (s_req !== 2'b11) begin errors++; $display("FAIL parallel s_req: got %b want 11", s_req); end
                checks++; if (s_cmd !== 2'b10) begin errors++; $display("FAIL parallel s_cmd: got %b want 10", s_cmd); end
                checks++; if (s_wdata[63:32] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL parallel s_wdata: got %h want deadbeef", s_wdata[63:32]); end
            end
            if (c == 2) begin
                checks++; if (m_ack !== 2'b11) begin errors++; $display("FAIL parallel m_ack: got %b want 11", m_ack); end
                checks++; if (m_rdata !== {32'h0, 32'h1234_5678}) begin errors++; $display("FAIL parallel m_rdata: got %h want 0000000012345678", m_rdata); end
                checks++; if (s_req !== 2'b00) begin errors++; $display("FAIL parallel s_req in resp: got %b want 00", s_req); end
            end
        end
    endtask

    // s0 never acks: timeout response in cycle 5, then a normal read.
    task automatic test_timeout();
        logic [1:0]  exp_ack, exp_err;
        logic        exp_req;
        logic [31:0] exp_rd;
        do_reset();
        for (int c = 0; c <= 9; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin m_req = 2'b01; m_cmd = 2'b00; m_addr[31:0] = 32'h0000_0010; end
            if (c == 6) m_addr[31:0] = 32'h0000_0020;
            s_ack   = (c == 7) ? 2'b01 : 2'b00;
            s_rdata[31:0] = (c == 7) ? 32'h0000_0777 : 32'hBAD0_BAD0;
            if (c == 9) m_req = 2'b00;
            @(negedge clk);
            exp_req = (c >= 1 && c <= 4) || (c == 7);
            exp_ack = (c == 5 || c == 8) ? 2'b01 : 2'b00;
            exp_err = (c == 5) ? 2'b01 : 2'b00;
            exp_rd  = (c == 8) ? 32'h0000_0777 : 32'h0;
            checks++; if (s_req !== {1'b0, exp_req}) begin errors++; $display("FAIL timeout s_req c%0d: got %b want %b", c, s_req, {1'b0, exp_req}); end
            checks++; if (m_ack !== exp_ack) begin errors++; $display("FAIL timeout m_ack c%0d: got %b want %b", c, m_ack, exp_ack); end
            checks++; if (m_err !== exp_err) begin errors++; $display("FAIL timeout m_err c%0d: got %b want %b", c, m_err, exp_err); end
            checks++; if (m_rdata[31:0] !== exp_rd) begin errors++; $display("FAIL timeout m_rdata c%0d: got %h want %h", c, m_rdata[31:0], exp_rd); end
            if (c == 7) begin
                checks++; if (s_addr[31:0] !== 32'h0000_0020) begin errors++; $display("FAIL timeout s_addr c%0d: got %h want 00000020", c, s_addr[31:0]); end
            end
        end
    endtask

    // s1 acks in the very cycle the timeout would expire: ack wins.
    task automatic test_ack_at_expiry();
        do_reset();
        for (int c = 0; c <= 6; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin m_req = 2'b10; m_cmd = 2'b00; m_addr[63:32] = 32'h8000_0000; end
            s_ack = (c == 4) ? 2'b10 : 2'b00;
            s_rdata[63:32] = (c == 4) ? 32'h0000_4444 : 32'h0;
            if (c == 6) m_req = 2'b00;
            @(negedge clk);
            if (c == 5) begin
                checks++; if (m_ack !== 2'b10) begin errors++; $display("FAIL ack_at_expiry m_ack: got %b want 10", m_ack); end
                checks++; if (m_err !== 2'b00) begin errors++; $display("FAIL ack_at_expiry m_err: got %b want 00", m_err); end
                checks++; if (m_rdata[63:32] !== 32'h0000_4444) begin errors++; $display("FAIL ack_at_expiry m_rdata: got %h want 00004444", m_rdata[63:32]); end
            end
        end
    endtask

    // 2x3 crossbar: m1 hits index 3 (decode error) while m0 reads s2.
    task automatic test_decode_err();
        logic [2:0] exp_sreq;
        logic [1:0] exp_ack, exp_err;
        do_reset();
        for (int c = 0; c <= 3; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                d3_m_req = 2'b11; d3_m_cmd = 2'b00;
                d3_m_addr = {32'hC000_0000, 32'h8000_0004};
            end
            d3_s_ack = (c == 1) ? 3'b100 : 3'b000;
            d3_s_rdata[95:64] = (c == 1) ? 32'h0000_3333 : 32'h0;
            if (c == 2) d3_m_req = 2'b00;
            @(negedge clk);
            exp_sreq = (c == 1) ? 3'b100 : 3'b000;
            exp_ack  = (c == 1) ? 2'b10 : ((c == 2) ? 2'b01 : 2'b00);
            exp_err  = (c == 1) ? 2'b10 : 2'b00;
            checks++; if (d3_s_req !== exp_sreq) begin errors++; $display("FAIL decode s_req c%0d: got %b want %b", c, d3_s_req, exp_sreq); end
            checks++; if (d3_m_ack !== exp_ack) begin errors++; $display("FAIL decode m_ack c%0d: got %b want %b", c, d3_m_ack, exp_ack); end
            checks++; if (d3_m_err !== exp_err) begin errors++; $display("FAIL decode m_err c%0d: got %b want %b", c, d3_m_err, exp_err); end
            if (c == 1) begin
                checks++; if (d3_m_rdata[63:32] !== 32'h0) begin errors++; $display("FAIL decode m_rdata c%0d: got %h want 0", c, d3_m_rdata[63:32]); end
            end
            if (c == 2) begin
                checks++; if (d3_m_rdata[31:0] !== 32'h0000_3333) begin errors++; $display("FAIL decode s2 m_rdata c%0d: got %h want 00003333", c, d3_m_rdata[31:0]); end
            end
        end
    endtask

    // m0 completes on s1 (rr_ptr -> 1), m1's s1 transfer is aborted by rst,
    // a late s_ack is ignored, then m0 wins a tie because rr_ptr is back to 0.
    task automatic test_reset_mid();
        logic [1:0] exp_req, exp_ack;
        do_reset();
        for (int c = 0; c <= 11; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin m_req = 2'b01; m_cmd = 2'b00; m_addr = {32'h8000_0100, 32'h8000_0000}; end
            if (c == 3) m_req = 2'b10;
            rst = (c == 5);
            if (c == 6) m_req = 2'b00;
            if (c == 8) m_req = 2'b11;
            s_ack = (c == 1 || c == 7 || c == 9) ? 2'b10 : 2'b00;
            s_rdata[63:32] = 32'h0000_5555;
            if (c == 11) m_req = 2'b00;
            @(negedge clk);
            exp_req = (c == 1 || c == 4 || c == 5 || c == 9) ? 2'b10 : 2'b00;
            exp_ack = (c == 2 || c == 10) ? 2'b01 : 2'b00;
            checks++; if (s_req !== exp_req) begin errors++; $display("FAIL reset_mid s_req c%0d: got %b want %b", c, s_req, exp_req); end
            checks++; if (m_ack !== exp_ack) begin errors++; $display("FAIL reset_mid m_ack c%0d: got %b want %b", c, m_ack, exp_ack); end
            if (c == 4 || c == 9) begin
                checks++;
                if (s_addr[63:32] !== ((c == 4) ? 32'h8000_0100 : 32'h8000_0000)) begin
                    errors++;
                    $display("FAIL reset_mid s_addr c%0d: got %h want %h", c, s_addr[63:32], (c == 4) ? 32'h8000_0100 : 32'h8000_0000);
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_read();
        test_contention();
        test_parallel();
        test_timeout();
        test_ack_at_expiry();
        test_decode_err();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
